// File: rtl/sram_march_bist_if.sv
// SRAM macro port bundle (csb0/web0/addr0/din0/dout0) between the March BIST
// controller (master) and the SRAM macro or its model (slave).
interface sram_march_bist_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7
);
  logic                  csb0;
  logic                  web0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] din0;
  logic [DATA_WIDTH-1:0] dout0;

  modport master (output csb0, web0, addr0, din0, input dout0);
  modport slave  (input csb0, web0, addr0, din0, output dout0);
endinterface

// File: rtl/sram_march_bist.sv
// March C- BIST controller for the single-port SRAM macro. Define
// BIST_FAIL_LOG_EN to build the first-failure capture registers and fail_count.
module sram_march_bist #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 7,
  parameter int                    READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] PATTERN      = 32'hFACECAFE
) (
  input  logic                  clk0,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic [7:0]            fail_count,
  sram_march_bist_if.master     sram
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    WAIT  = 3'd3,
    CHECK = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_MIN  = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = {ADDR_WIDTH{1'b1}};
  localparam logic [1:0]            WAIT_LAST = 2'(READ_LATENCY - 1);

  state_t                state_r, state_s;
  logic [2:0]            elem_r, elem_s;
  logic [ADDR_WIDTH-1:0] addr_r, addr_s;
  logic [1:0]            wcnt_r, wcnt_s;
  logic [DATA_WIDTH-1:0] din_r, din_s;
  logic                  csb_r, csb_s;
  logic                  web_r, web_s;
  logic                  busy_r, busy_s;
  logic                  done_r, done_s;
  logic                  fail_r;
  logic                  up_s;
  logic                  last_s;
  logic                  accept_s;
  logic                  mismatch_s;
  logic [DATA_WIDTH-1:0] expect_s;

  // Elements E0..E2 sweep upward, E3..E5 downward.
  assign up_s     = (elem_r <= 3'd2);
  assign last_s   = up_s ? (addr_r == ADDR_MAX) : (addr_r == ADDR_MIN);
  assign accept_s = (state_r == IDLE) && start;
  // Odd elements read back P, even elements read back ~P.
  assign expect_s   = elem_r[0] ? PATTERN : ~PATTERN;
  assign mismatch_s = (state_r == CHECK) && (sram.dout0 != expect_s);

  // Next-state, element/address sequencing and registered port values.
  always_comb begin
    state_s = state_r;
    elem_s  = elem_r;
    addr_s  = addr_r;
    wcnt_s  = wcnt_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = WRITE;
          elem_s  = 3'd0;
          addr_s  = ADDR_MIN;
        end else begin
          state_s = IDLE;
        end
      end
      WRITE: begin
        if (addr_r == ADDR_MAX) begin
          state_s = READ;
          elem_s  = 3'd1;
          addr_s  = ADDR_MIN;
        end else begin
          addr_s  = addr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end
      end
      READ: begin
        state_s = WAIT;
        wcnt_s  = 2'd0;
      end
      WAIT: begin
        if (wcnt_r == WAIT_LAST) begin
          state_s = CHECK;
        end else begin
          wcnt_s  = wcnt_r + 2'd1;
        end
      end
      CHECK: begin
        if (last_s && (elem_r == 3'd5)) begin
          state_s = DONE;
        end else if (last_s) begin
          state_s = READ;
          elem_s  = elem_r + 3'd1;
          addr_s  = (elem_r + 3'd1 <= 3'd2) ? ADDR_MIN : ADDR_MAX;
        end else begin
          state_s = READ;
          addr_s  = up_s ? addr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1}
                         : addr_r - {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase

    // Port values are derived from the upcoming state so they are registered.
    csb_s  = 1'b1;
    web_s  = 1'b1;
    din_s  = din_r;
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_s)
      WRITE: begin
        csb_s  = 1'b0;
        web_s  = 1'b0;
        din_s  = PATTERN;
        busy_s = 1'b1;
      end
      READ: begin
        csb_s  = 1'b0;
        busy_s = 1'b1;
      end
      WAIT:  busy_s = 1'b1;
      CHECK: begin
        busy_s = 1'b1;
        if (elem_s != 3'd5) begin
          csb_s = 1'b0;
          web_s = 1'b0;
          din_s = elem_s[0] ? ~PATTERN : PATTERN;
        end else begin
          din_s = din_r;
        end
      end
      DONE:    done_s = 1'b1;
      IDLE:    done_s = 1'b0;
      default: done_s = 1'b0;
    endcase
  end

  // Sequencer and SRAM port registers.
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      elem_r  <= 3'd0;
      addr_r  <= ADDR_MIN;
      wcnt_r  <= 2'd0;
      din_r   <= {DATA_WIDTH{1'b0}};
      csb_r   <= 1'b1;
      web_r   <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      elem_r  <= elem_s;
      addr_r  <= addr_s;
      wcnt_r  <= wcnt_s;
      din_r   <= din_s;
      csb_r   <= csb_s;
      web_r   <= web_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  // Sticky fail flag; a mismatch never interrupts the sequence.
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      fail_r <= 1'b0;
    end else if (accept_s) begin
      fail_r <= 1'b0;
    end else if (mismatch_s) begin
      fail_r <= 1'b1;
    end
  end

`ifdef BIST_FAIL_LOG_EN
  logic [ADDR_WIDTH-1:0] fail_addr_r;
  logic [2:0]            fail_elem_r;
  logic [DATA_WIDTH-1:0] fail_data_r;
  logic [7:0]            fail_count_r;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      sat_inc8 = v;
    end else begin
      sat_inc8 = v + 8'd1;
    end
  endfunction

  // First-failure capture and saturating mismatch counter.
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      fail_addr_r  <= ADDR_MIN;
      fail_elem_r  <= 3'd0;
      fail_data_r  <= {DATA_WIDTH{1'b0}};
      fail_count_r <= 8'd0;
    end else if (accept_s) begin
      fail_addr_r  <= ADDR_MIN;
      fail_elem_r  <= 3'd0;
      fail_data_r  <= {DATA_WIDTH{1'b0}};
      fail_count_r <= 8'd0;
    end else if (mismatch_s) begin
      fail_count_r <= sat_inc8(fail_count_r);
      if (!fail_r) begin
        fail_addr_r <= addr_r;
        fail_elem_r <= elem_r;
        fail_data_r <= sram.dout0;
      end
    end
  end

  assign fail_addr  = fail_addr_r;
  assign fail_elem  = fail_elem_r;
  assign fail_data  = fail_data_r;
  assign fail_count = fail_count_r;
`else
  assign fail_addr  = ADDR_MIN;
  assign fail_elem  = 3'd0;
  assign fail_data  = {DATA_WIDTH{1'b0}};
  assign fail_count = 8'd0;
`endif

  assign busy       = busy_r;
  assign done       = done_r;
  assign fail       = fail_r;
  assign sram.csb0  = csb_r;
  assign sram.web0  = web_r;
  assign sram.addr0 = addr_r;
  assign sram.din0  = din_r;

endmodule
